bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq_pkg.sv | 16 +
 rtl/bin2bcd_seq_bcd_adj3.sv | 16 +
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int BCD_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_adj3.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more.
module bcd_adj3
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] d_i,
    output logic [BCD_W-1:0] d_o
);

    always_comb begin
        d_o = d_i;
        if (d_i >= 4'd5) begin
            d_o = d_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one bit per clock, start/busy/done handshake.
// Handshake: start is taken on an edge while idle (busy=0); busy stays high for
// WIDTH cycles; done pulses for one cycle together with the new bcd_out/digit_nz.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]         digit_nz,
    output state_e                    state_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam int BW = BCD_W * DIGITS;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     work_q, work_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] nz_q, nz_d;
    logic              done_q, done_d;

    logic [BW-1:0]     work_adj;
    logic [BW-1:0]     work_shift;

    // Bit k set when digit k or any more significant digit is nonzero.
    function automatic logic [DIGITS-1:0] lead_mask(input logic [BW-1:0] v);
        logic              acc;
        logic [DIGITS-1:0] m;
        acc = 1'b0;
        m   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc  = acc | (|v[BCD_W*k +: BCD_W]);
            m[k] = acc;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .d_i (work_q[BCD_W*g +: BCD_W]),
            .d_o (work_adj[BCD_W*g +: BCD_W])
        );
    end

    assign work_shift = {work_adj[BW-2:0], bin_q[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        nz_d    = nz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    work_d  = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d  = bin_q << 1;
                work_d = work_shift;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = work_shift;
                    nz_d    = lead_mask(work_shift);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            nz_q    <= DIGITS'(1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            nz_q    <= nz_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign digit_nz = nz_q;
    assign state_o  = state_q;

endmodule
